// File: rtl/captura_pkg.sv
// Shared definitions for the camera frame-capture controller: the capture
// state enumeration, frame-buffer address width and default geometry.
package captura_pkg;

    localparam int ADDR_W      = 17;
    localparam int LINE_W      = 8;
    localparam int H_PIX_DEF   = 320;
    localparam int V_LINES_DEF = 240;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_CAPTURE  = 2'd2,
        ST_DONE     = 2'd3
    } cap_state_t;

endpackage

// File: rtl/detector_flanco.sv
// Edge detector: keeps the previous sample of a level input and emits
// registered one-cycle rise/fall strobes.
module detector_flanco (
    input  logic PCLK,
    input  logic rst,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic sig_q;

    // Sample the level and register the edge strobes against the previous sample.
    always_ff @(posedge PCLK or posedge rst) begin
        if (rst) begin
            sig_q <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sig_q <= sig;
            rise  <= sig & ~sig_q;
            fall  <= ~sig & sig_q;
        end
    end

endmodule

// File: rtl/captura_frame_ctrl.sv
// Camera frame-capture controller. Arms on start, waits for the start of a
// frame (VSYNC falling), writes one frame-buffer word per assembled pixel,
// and closes the frame on VSYNC rising or after V_LINES lines.
// Optional build macro CAPTURA_LINE_CHECK_EN adds a per-line pixel-count
// check feeding err_line; without it err_line reports address overflow only.
module captura_frame_ctrl
    import captura_pkg::*;
#(
    parameter int H_PIX   = H_PIX_DEF,
    parameter int V_LINES = V_LINES_DEF
) (
    input  logic              PCLK,
    input  logic              rst,
    input  logic              start,
    input  logic              continuous,
    input  logic              VSYNC,
    input  logic              HREF,
    input  logic              pix_we_in,
    output logic              cap_en,
    output logic [ADDR_W-1:0] DP_RAM_addr_in,
    output logic              DP_RAM_regW,
    output logic              busy,
    output logic              frame_done,
    output logic              err_line,
    output logic [LINE_W-1:0] line_cnt
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(H_PIX * V_LINES - 1);

    function automatic logic [LINE_W-1:0] sat_inc_line(input logic [LINE_W-1:0] v);
        return (v == {LINE_W{1'b1}}) ? v : v + LINE_W'(1);
    endfunction

    function automatic logic [ADDR_W-1:0] sat_inc_addr(input logic [ADDR_W-1:0] v,
                                                       input logic [ADDR_W-1:0] lim);
        return (v == lim) ? v : v + ADDR_W'(1);
    endfunction

    cap_state_t        state, state_n;
    logic              vs_rise, vs_fall;
    logic              hr_rise_unused, hr_fall;
    logic              sof;
    logic              lines_done;
    logic              pix_hit;
    logic              accept;
    logic              drop;
    logic              full;
    logic              line_bad;
    logic [ADDR_W-1:0] addr_nxt;

    detector_flanco u_det_vsync (
        .PCLK (PCLK),
        .rst  (rst),
        .sig  (VSYNC),
        .rise (vs_rise),
        .fall (vs_fall)
    );

    // The line start is implied by HREF itself; only the line end is used.
    detector_flanco u_det_href (
        .PCLK (PCLK),
        .rst  (rst),
        .sig  (HREF),
        .rise (hr_rise_unused),
        .fall (hr_fall)
    );

    assign sof        = (state == ST_WAIT_SOF) && vs_fall;
    assign lines_done = (int'(line_cnt) >= V_LINES);
    assign pix_hit    = pix_we_in && HREF && (state == ST_CAPTURE);
    // A strobe in the cycle the frame closes would write outside CAPTURE, so it is not taken.
    assign accept     = pix_hit && !full && (state_n == ST_CAPTURE);
    assign drop       = pix_hit && full;
    // Address the next accepted strobe will be written to (a pending write has not advanced it yet).
    assign addr_nxt   = DP_RAM_addr_in + ADDR_W'(DP_RAM_regW);

    // State register.
    always_ff @(posedge PCLK or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and state-decoded outputs; VSYNC rising wins over the line limit and any fall in CAPTURE.
    always_comb begin
        state_n    = state;
        busy       = 1'b1;
        cap_en     = 1'b0;
        frame_done = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_n = ST_WAIT_SOF;
            end
            ST_WAIT_SOF: begin
                cap_en = 1'b1;
                if (vs_fall) state_n = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                cap_en = 1'b1;
                if (vs_rise || lines_done) state_n = ST_DONE;
            end
            ST_DONE: begin
                frame_done = 1'b1;
                state_n    = continuous ? ST_WAIT_SOF : ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Write stage: strobe accepted now, write issued next cycle, address advanced after the write.
    always_ff @(posedge PCLK or posedge rst) begin
        if (rst) begin
            DP_RAM_regW    <= 1'b0;
            DP_RAM_addr_in <= '0;
            full           <= 1'b0;
        end else begin
            DP_RAM_regW <= accept;
            if (sof) begin
                DP_RAM_addr_in <= '0;
                full           <= 1'b0;
            end else begin
                if (DP_RAM_regW) DP_RAM_addr_in <= sat_inc_addr(DP_RAM_addr_in, ADDR_MAX);
                if (accept && (addr_nxt == ADDR_MAX)) full <= 1'b1;
            end
        end
    end

    // Line counter and sticky error flag.
    always_ff @(posedge PCLK or posedge rst) begin
        if (rst) begin
            line_cnt <= '0;
            err_line <= 1'b0;
        end else begin
            if (sof) begin
                line_cnt <= '0;
            end else if ((state == ST_CAPTURE) && hr_fall) begin
                line_cnt <= sat_inc_line(line_cnt);
            end
            if ((state == ST_IDLE) && start) begin
                err_line <= 1'b0;
            end else if (drop || line_bad) begin
                err_line <= 1'b1;
            end
        end
    end

`ifdef CAPTURA_LINE_CHECK_EN
    logic [ADDR_W-1:0] pix_cnt;

    assign line_bad = (state == ST_CAPTURE) && hr_fall && (pix_cnt != ADDR_W'(H_PIX));

    // Count strobes on the current line; a strobe coinciding with the line-end strobe opens the next line.
    always_ff @(posedge PCLK or posedge rst) begin
        if (rst) begin
            pix_cnt <= '0;
        end else if (sof) begin
            pix_cnt <= '0;
        end else if ((state == ST_CAPTURE) && hr_fall) begin
            pix_cnt <= pix_hit ? ADDR_W'(1) : '0;
        end else if (pix_hit) begin
            pix_cnt <= sat_inc_addr(pix_cnt, {ADDR_W{1'b1}});
        end
    end
`else
    assign line_bad = 1'b0;
`endif

endmodule

// File: tb/tb_captura_frame_ctrl.sv
// Self-checking bench for captura_frame_ctrl with a reduced frame geometry.
// Random pixel spacing and line lengths; expectations come from a frame-level
// model (write count, address order, error flag, line count).
module tb_captura_frame_ctrl;

    localparam int H     = 16;
    localparam int V     = 6;
    localparam int NPIX  = H * V;
`ifdef CAPTURA_LINE_CHECK_EN
    localparam bit LCHK = 1'b1;
`else
    localparam bit LCHK = 1'b0;
`endif

    logic        PCLK = 1'b0;
    logic        rst;
    logic        start;
    logic        continuous;
    logic        VSYNC;
    logic        HREF;
    logic        pix_we_in;
    logic        cap_en;
    logic [16:0] DP_RAM_addr_in;
    logic        DP_RAM_regW;
    logic        busy;
    logic        frame_done;
    logic        err_line;
    logic [7:0]  line_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int busy_drop = 0;
    int exp_addr = 0;
    bit watch_busy = 1'b0;
    int plan[$];

    captura_frame_ctrl #(.H_PIX(H), .V_LINES(V)) dut (
        .PCLK           (PCLK),
        .rst            (rst),
        .start          (start),
        .continuous     (continuous),
        .VSYNC          (VSYNC),
        .HREF           (HREF),
        .pix_we_in      (pix_we_in),
        .cap_en         (cap_en),
        .DP_RAM_addr_in (DP_RAM_addr_in),
        .DP_RAM_regW    (DP_RAM_regW),
        .busy           (busy),
        .frame_done     (frame_done),
        .err_line       (err_line),
        .line_cnt       (line_cnt)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Write monitor: every write must land on the next expected address in order.
    always @(negedge PCLK) begin
        if (!rst) begin
            if (DP_RAM_regW) begin
                wr_cnt++;
                chk_val("wr_addr", 32'(DP_RAM_addr_in), 32'(exp_addr));
                chk_val("wr_in_capture", 32'(cap_en & ~frame_done), 32'd1);
                exp_addr++;
            end
            if (frame_done) done_cnt++;
            if (watch_busy && !busy) busy_drop++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge PCLK);
            #1;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic sof();
        VSYNC = 1'b1;
        tick(3);
        VSYNC = 1'b0;
        tick(4);
    endtask

    task automatic eof();
        VSYNC = 1'b1;
        tick(5);
    endtask

    task automatic send_line(input int n, input int start_at);
        HREF = 1'b1;
        tick(1);
        for (int i = 0; i < n; i++) begin
            pix_we_in = 1'b1;
            if (i == start_at) start = 1'b1;
            tick(1);
            pix_we_in = 1'b0;
            start = 1'b0;
            tick(int'($urandom_range(0, 2)));
        end
        HREF = 1'b0;
        tick(4);
    endtask

    // Runs one frame from the plan and checks it against the frame-level model.
    task automatic run_frame(input int start_line, input int start_pix);
        int total;
        int exp_wr;
        bit exp_err;
        int w0;
        int d0;
        total = 0;
        exp_err = 1'b0;
        w0 = wr_cnt;
        d0 = done_cnt;
        exp_addr = 0;
        sof();
        foreach (plan[i]) begin
            send_line(plan[i], (i == start_line) ? start_pix : -1);
            total += plan[i];
            if (LCHK && plan[i] != H) exp_err = 1'b1;
        end
        eof();
        exp_wr = (total > NPIX) ? NPIX : total;
        if (total > NPIX) exp_err = 1'b1;
        chk_val("frame_writes", 32'(wr_cnt - w0), 32'(exp_wr));
        chk_val("frame_done_cnt", 32'(done_cnt - d0), 32'd1);
        chk_val("line_cnt", 32'(line_cnt), 32'(plan.size()));
        chk_val("err_line", 32'(err_line), 32'(exp_err));
        chk_val("busy_after_frame", 32'(busy), 32'(continuous));
    endtask

    initial begin
        int w0;
        rst = 1'b1;
        start = 1'b0;
        continuous = 1'b0;
        VSYNC = 1'b1;
        HREF = 1'b0;
        pix_we_in = 1'b0;
        tick(3);
        chk_val("rst_busy", 32'(busy), 32'd0);
        chk_val("rst_cap_en", 32'(cap_en), 32'd0);
        chk_val("rst_regW", 32'(DP_RAM_regW), 32'd0);
        chk_val("rst_addr", 32'(DP_RAM_addr_in), 32'd0);
        chk_val("rst_done", 32'(frame_done), 32'd0);
        chk_val("rst_err", 32'(err_line), 32'd0);
        chk_val("rst_line_cnt", 32'(line_cnt), 32'd0);
        @(negedge PCLK);
        rst = 1'b0;
        tick(2);
        chk_val("idle_no_start_busy", 32'(busy), 32'd0);

        // Single full frame.
        do_start();
        chk_val("armed_busy", 32'(busy), 32'd1);
        chk_val("armed_cap_en", 32'(cap_en), 32'd1);
        plan.delete();
        for (int l = 0; l < V; l++) plan.push_back(H);
        run_frame(-1, -1);

        // Continuous mode: two frames with busy held, then a closing frame.
        continuous = 1'b1;
        do_start();
        watch_busy = 1'b1;
        run_frame(-1, -1);
        run_frame(-1, -1);
        watch_busy = 1'b0;
        chk_val("cont_busy_held", 32'(busy_drop), 32'd0);
        continuous = 1'b0;
        plan.delete();
        plan.push_back(H);
        plan.push_back(H);
        run_frame(-1, -1);

        // Short line in line 2.
        do_start();
        plan.delete();
        for (int l = 0; l < V; l++) plan.push_back((l == 2) ? H - 1 : H);
        run_frame(-1, -1);

        // Overflow: more strobes than the frame holds, in one long line.
        do_start();
        chk_val("err_clr_on_start", 32'(err_line), 32'd0);
        plan.delete();
        plan.push_back(NPIX + 10);
        run_frame(-1, -1);

        // Start pulse in the middle of a capture is ignored.
        do_start();
        plan.delete();
        for (int l = 0; l < V; l++) plan.push_back(H);
        run_frame(2, 4);

        // Reset in the middle of a frame.
        do_start();
        exp_addr = 0;
        sof();
        HREF = 1'b1;
        tick(1);
        for (int i = 0; i < 40; i++) begin
            pix_we_in = 1'b1;
            tick(1);
            pix_we_in = 1'b0;
            tick(int'($urandom_range(0, 1)));
        end
        pix_we_in = 1'b1;
        @(posedge PCLK);
        #2 rst = 1'b1;
        #1;
        chk_val("midrst_regW", 32'(DP_RAM_regW), 32'd0);
        chk_val("midrst_busy", 32'(busy), 32'd0);
        chk_val("midrst_addr", 32'(DP_RAM_addr_in), 32'd0);
        chk_val("midrst_cap_en", 32'(cap_en), 32'd0);
        @(negedge PCLK);
        rst = 1'b0;
        w0 = wr_cnt;
        for (int i = 0; i < 20; i++) begin
            pix_we_in = 1'b1;
            tick(1);
            pix_we_in = 1'b0;
            tick(1);
        end
        sof();
        for (int i = 0; i < 10; i++) begin
            pix_we_in = 1'b1;
            tick(1);
            pix_we_in = 1'b0;
            tick(1);
        end
        HREF = 1'b0;
        tick(3);
        chk_val("postrst_writes", 32'(wr_cnt - w0), 32'd0);
        chk_val("postrst_busy", 32'(busy), 32'd0);

        // Randomized frames: random line count and line lengths around H.
        for (int f = 0; f < 4; f++) begin
            int nl;
            nl = int'($urandom_range(1, V));
            plan.delete();
            for (int l = 0; l < nl; l++) plan.push_back(H - 2 + int'($urandom_range(0, 4)));
            do_start();
            run_frame(-1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
